qpsk_ctrl_sequencer: RTL

Run controller for the QPSK link under lab control. It takes start/enable/phase commands from either board switches or VIO probes, then sequences the link through reset, TX warm-up, RX lock acquisition and a timed BER measurement window. It drives reset/enable/phase controls into the QPSK comm system and returns state and status for ILA/VIO/LED observation.

---
 rtl/qpsk_ctrl_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/qpsk_ctrl_sequencer.sv
// Run sequencer for the QPSK lab link: reset, TX warm-up, RX lock, timed BER window.
// Optional build macro CTRL_AUTO_RERUN_EN: DONE rolls straight into a fresh RUN window.
module qpsk_ctrl_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned WARMUP_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned NB_WIN        = 32
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_src_vio,
    input  logic              i_sw_start,
    input  logic              i_sw_enable,
    input  logic [1:0]        i_sw_phase,
    input  logic              i_vio_start,
    input  logic              i_vio_enable,
    input  logic [1:0]        i_vio_phase,
    input  logic              i_rx_lock,
    input  logic [NB_WIN-1:0] i_ber_window,
    output logic              o_sys_rst,
    output logic              o_tx_en,
    output logic              o_rx_en,
    output logic [1:0]        o_phase_sel,
    output logic              o_ber_clr,
    output logic              o_ber_run,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_state,
    output logic [3:0]        o_led
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_SYNC   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [3:0]        sync1_q, sync2_q;
    logic              src_q, prev_q;
    logic              start_m, en_m, start_pulse, accept;
    logic [1:0]        phase_m;
    logic [2:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [NB_WIN-1:0] win_q, win_d, win_len_q, win_len_d;
    logic [1:0]        phase_q, phase_d;
    logic              sys_rst_q, tx_en_q, rx_en_q, clr_q, run_q, done_q, err_q;

    always_comb begin
        start_m = i_src_vio ? i_vio_start  : sync2_q[0];
        en_m    = i_src_vio ? i_vio_enable : sync2_q[1];
        phase_m = i_src_vio ? i_vio_phase  : sync2_q[3:2];
    end

    // A source switch reloads the edge history, so no edge is taken that cycle
    assign start_pulse = start_m & ~prev_q & (i_src_vio == src_q);
    assign accept      = start_pulse & en_m;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        win_d     = win_q;
        win_len_d = win_len_q;
        phase_d   = phase_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (accept) begin
                    state_d = S_RESET;
                    phase_d = phase_m;
                end
            end
            S_RESET: begin
                if (cnt_q == RST_CYCLES - 1) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (cnt_q == WARMUP_CYCLES - 1) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (i_rx_lock)                      state_d = S_RUN;
                else if (cnt_q == LOCK_TIMEOUT - 1) state_d = S_ERROR;
            end
            S_RUN: begin
                if (!i_rx_lock) begin
                    state_d = S_SYNC;
                end else if (!run_q) begin
                    win_d = '0;
                end else begin
                    win_d = win_q + 1'b1;
                    if (win_len_q != '0 && win_d == win_len_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef CTRL_AUTO_RERUN_EN
                state_d = S_RUN;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (!en_m && state_q != S_IDLE && state_q != S_ERROR) state_d = S_IDLE;
        if (state_d != state_q) cnt_d = '0;
        if (state_d == S_RUN && state_q != S_RUN) win_len_d = i_ber_window;
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            src_q     <= 1'b0;
            prev_q    <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            win_len_q <= '0;
            phase_q   <= '0;
            sys_rst_q <= 1'b1;
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            clr_q     <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= {i_sw_phase, i_sw_enable, i_sw_start};
            sync2_q   <= sync1_q;
            src_q     <= i_src_vio;
            prev_q    <= start_m;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            win_len_q <= win_len_d;
            phase_q   <= phase_d;
            sys_rst_q <= (state_d == S_IDLE) || (state_d == S_RESET) ||
                         (state_d == S_ERROR);
            tx_en_q   <= (state_d == S_WARMUP) || (state_d == S_SYNC) ||
                         (state_d == S_RUN) || (state_d == S_DONE);
            rx_en_q   <= (state_d == S_SYNC) || (state_d == S_RUN) ||
                         (state_d == S_DONE);
            clr_q     <= (state_d == S_RUN) && (state_q != S_RUN);
            run_q     <= (state_d == S_RUN) && (state_q == S_RUN);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERROR);
        end
    end

    assign o_sys_rst   = sys_rst_q;
    assign o_tx_en     = tx_en_q;
    assign o_rx_en     = rx_en_q;
    assign o_phase_sel = phase_q;
    assign o_ber_clr   = clr_q;
    assign o_ber_run   = run_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_state     = state_q;
    assign o_led       = {err_q, run_q, rx_en_q, tx_en_q};

endmodule
